// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch-predictor update scheduler.
// The bp_entry_t layout uses the default index width; other widths use a local struct.
package bp_pkg;

    localparam int BP_IDX_W = 6;
    localparam int BP_DEPTH = 4;

    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                taken;
    } bp_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RECOVER = 2'd2
    } bp_state_e;

endpackage

// File: rtl/bp_fifo.sv
// In-order circular buffer of outstanding predictions with push/pop/clear.
// Occupancy is kept separately so that full and empty are distinguishable.
module bp_fifo
    import bp_pkg::*;
#(
    parameter int  DEPTH   = BP_DEPTH,
    parameter type entry_t = bp_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   din,
    input  logic                     pop,
    input  logic                     clear,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/bp_update_sched.sv
// Pattern-table update scheduler: queues ID predictions, matches in-order resolves,
// emits one update per resolved branch and a redirect on mispredict. Optional: BP_STATS_EN.
module bp_update_sched
    import bp_pkg::*;
#(
    parameter int DEPTH       = BP_DEPTH,
    parameter int IDX_W       = BP_IDX_W,
    parameter int RECOVER_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enq_valid,
    input  logic [IDX_W-1:0]        enq_idx,
    input  logic                    enq_taken,
    output logic                    enq_ready,
    input  logic                    res_valid,
    input  logic                    res_taken,
    input  logic                    squash,
    output logic                    upd_valid,
    output logic [IDX_W-1:0]        upd_idx,
    output logic                    upd_inc,
    output logic                    mispredict,
    output logic [$clog2(DEPTH):0]  occupancy
`ifdef BP_STATS_EN
    ,
    output logic [31:0]             stat_branches,
    output logic [31:0]             stat_miss
`endif
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int RC_W  = $clog2(RECOVER_CYC + 1);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_ACTIVE  = ACTIVE;
    localparam logic [1:0] ST_RECOVER = RECOVER;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } entry_t;

    logic [1:0]      state;
    logic [RC_W-1:0] rcnt;
    entry_t          head;
    entry_t          din;
    logic            enq_acc;
    logic            res_act;
    logic            mis;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_clear;

    assign enq_ready = (state != ST_RECOVER) && (occupancy < OCC_W'(DEPTH));
    assign enq_acc   = enq_valid && enq_ready;
    assign res_act   = res_valid && (occupancy != '0);
    assign mis       = res_act && (head.taken != res_taken);

    // A miss or squash kills everything younger, including a same-cycle enqueue.
    assign fifo_clear = squash || mis;
    assign fifo_push  = enq_acc && !fifo_clear;
    assign fifo_pop   = res_act && !fifo_clear;
    assign din        = '{idx: enq_idx, taken: enq_taken};

    bp_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .din       (din),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .head      (head),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            rcnt  <= '0;
        end else if (squash) begin
            state <= ST_IDLE;
            rcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_push) state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (mis) begin
                        state <= ST_RECOVER;
                        rcnt  <= RC_W'(RECOVER_CYC);
                    end else if (fifo_pop && !fifo_push && occupancy == OCC_W'(1)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RECOVER: begin
                    rcnt <= rcnt - RC_W'(1);
                    if (rcnt == RC_W'(1)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid  <= 1'b0;
            upd_idx    <= '0;
            upd_inc    <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            upd_valid  <= res_act;
            mispredict <= mis && !squash;
            if (res_act) begin
                upd_idx <= head.idx;
                upd_inc <= ~res_taken;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches <= '0;
            stat_miss     <= '0;
        end else begin
            if (res_act)          stat_branches <= stat_branches + 32'd1;
            if (mis && !squash)   stat_miss     <= stat_miss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched with hand-computed expectations.
module tb_bp_update_sched;

    logic       clk;
    logic       rst_n;
    logic       enq_valid;
    logic [5:0] enq_idx;
    logic       enq_taken;
    logic       enq_ready;
    logic       res_valid;
    logic       res_taken;
    logic       squash;
    logic       upd_valid;
    logic [5:0] upd_idx;
    logic       upd_inc;
    logic       mispredict;
    logic [2:0] occupancy;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_miss;
`endif

    int checks = 0;
    int errors = 0;

    bp_update_sched #(.DEPTH(4), .IDX_W(6), .RECOVER_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enq_valid  (enq_valid),
        .enq_idx    (enq_idx),
        .enq_taken  (enq_taken),
        .enq_ready  (enq_ready),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .squash     (squash),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_inc    (upd_inc),
        .mispredict (mispredict),
        .occupancy  (occupancy)
`ifdef BP_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_miss     (stat_miss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid = 1'b0;
        enq_idx   = '0;
        enq_taken = 1'b0;
        res_valid = 1'b0;
        res_taken = 1'b0;
        squash    = 1'b0;
    endtask

    task automatic enq(input logic [5:0] idx, input logic tk);
        enq_valid = 1'b1;
        enq_idx   = idx;
        enq_taken = tk;
    endtask

    task automatic res(input logic tk);
        res_valid = 1'b1;
        res_taken = tk;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("rst_upd_idx", 32'(upd_idx), 32'd0);
        chk("rst_upd_inc", 32'(upd_inc), 32'd0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        rst_n = 1'b1;
        tick();

        // single branch, correct prediction
        enq(6'd5, 1'b1);
        tick();
        chk("single_occ1", 32'(occupancy), 32'd1);
        chk("single_noupd", 32'(upd_valid), 32'd0);
        idle_inputs();
        res(1'b1);
        tick();
        chk("single_upd_valid", 32'(upd_valid), 32'd1);
        chk("single_upd_idx", 32'(upd_idx), 32'd5);
        chk("single_upd_inc", 32'(upd_inc), 32'd0);
        chk("single_mis", 32'(mispredict), 32'd0);
        chk("single_occ0", 32'(occupancy), 32'd0);
        idle_inputs();
        tick();
        chk("single_upd_pulse", 32'(upd_valid), 32'd0);

        // mispredict flush and recovery window
        enq(6'd1, 1'b0); tick();
        enq(6'd2, 1'b0); tick();
        enq(6'd3, 1'b0); tick();
        chk("flush_occ3", 32'(occupancy), 32'd3);
        idle_inputs();
        res(1'b1);
        enq(6'd9, 1'b1);
        tick();
        chk("flush_upd_idx", 32'(upd_idx), 32'd1);
        chk("flush_upd_inc", 32'(upd_inc), 32'd0);
        chk("flush_mis", 32'(mispredict), 32'd1);
        chk("flush_occ0", 32'(occupancy), 32'd0);
        chk("flush_ready_c1", 32'(enq_ready), 32'd0);
        idle_inputs();
        enq(6'd9, 1'b1);
        tick();
        chk("flush_mis_pulse", 32'(mispredict), 32'd0);
        chk("flush_ready_c2", 32'(enq_ready), 32'd0);
        chk("flush_rec_noacc", 32'(occupancy), 32'd0);
        idle_inputs();
        tick();
        chk("flush_ready_back", 32'(enq_ready), 32'd1);

        // full back-pressure
        for (int i = 0; i < 4; i++) begin
            enq(6'(10 + i), 1'b1);
            tick();
        end
        chk("full_occ4", 32'(occupancy), 32'd4);
        chk("full_ready0", 32'(enq_ready), 32'd0);
        enq(6'd14, 1'b1);
        tick();
        chk("full_5th_rejected", 32'(occupancy), 32'd4);
        res(1'b1);
        tick();
        chk("full_pop_occ3", 32'(occupancy), 32'd3);
        chk("full_pop_idx", 32'(upd_idx), 32'd10);
        tick();
        chk("enqres_occ_same", 32'(occupancy), 32'd3);
        chk("enqres_idx", 32'(upd_idx), 32'd11);
        idle_inputs();
        res(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_idx", 32'(upd_idx), 32'(12 + i));
            chk("drain_mis", 32'(mispredict), 32'd0);
        end
        idle_inputs();
        tick();
        chk("drain_occ0", 32'(occupancy), 32'd0);

        // squash colliding with a mispredicting resolve
        enq(6'd20, 1'b1); tick();
        enq(6'd21, 1'b1); tick();
        enq(6'd22, 1'b1);
        res(1'b0);
        squash = 1'b1;
        tick();
        chk("sq_upd_valid", 32'(upd_valid), 32'd1);
        chk("sq_upd_idx", 32'(upd_idx), 32'd20);
        chk("sq_upd_inc", 32'(upd_inc), 32'd1);
        chk("sq_mis", 32'(mispredict), 32'd0);
        chk("sq_occ0", 32'(occupancy), 32'd0);
        chk("sq_ready", 32'(enq_ready), 32'd1);
        idle_inputs();
        tick();
        chk("sq_after_noupd", 32'(upd_valid), 32'd0);

        // resolve with empty queue, then enq+resolve on empty
        res(1'b1);
        tick();
        chk("empty_res_noupd", 32'(upd_valid), 32'd0);
        enq(6'd7, 1'b0);
        tick();
        chk("empty_enqres_noupd", 32'(upd_valid), 32'd0);
        chk("empty_enqres_occ1", 32'(occupancy), 32'd1);
        idle_inputs();
        res(1'b0);
        tick();
        chk("empty_enqres_idx", 32'(upd_idx), 32'd7);
        chk("empty_enqres_inc", 32'(upd_inc), 32'd1);
        chk("empty_enqres_occ0", 32'(occupancy), 32'd0);

        // pointer wrap
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            enq((i % 2 == 0) ? 6'h3F : 6'h00, (i % 2 == 0) ? 1'b1 : 1'b0);
            tick();
            idle_inputs();
            res((i % 2 == 0) ? 1'b1 : 1'b0);
            tick();
            chk("wrap_idx", 32'(upd_idx), (i % 2 == 0) ? 32'h3F : 32'h00);
            chk("wrap_inc", 32'(upd_inc), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("wrap_mis", 32'(mispredict), 32'd0);
        end
        idle_inputs();
        tick();
        chk("wrap_occ0", 32'(occupancy), 32'd0);

        // async reset mid-operation
        enq(6'd30, 1'b1); tick();
        enq(6'd31, 1'b1); tick();
        idle_inputs();
        res(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_occ0", 32'(occupancy), 32'd0);
        chk("arst_ready", 32'(enq_ready), 32'd1);
        #10;
        rst_n = 1'b1;
        tick();
        chk("arst_noupd", 32'(upd_valid), 32'd0);
        idle_inputs();
        tick();

`ifdef BP_STATS_EN
        chk("stat_zero_b", stat_branches, 32'd0);
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            enq(6'(i), 1'b0);
            tick();
            idle_inputs();
            res((i == 1 || i == 4) ? 1'b1 : 1'b0);
            tick();
            idle_inputs();
            tick();
            tick();
        end
        chk("stat_branches", stat_branches, 32'd6);
        chk("stat_miss", stat_miss, 32'd2);
        enq(6'd40, 1'b1); tick();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("stat_rst_b", stat_branches, 32'd0);
        chk("stat_rst_m", stat_miss, 32'd0);
        chk("stat_rst_occ", 32'(occupancy), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
